cpu_core_param: RTL

//  Parametrised multi-cycle accumulator-style CPU core; generalises the 3-bit/9-bit-instruction CPU to DATA_W-bit data,
//  2^ADDR_W-word unified program/data RAM, conditional jumps, LOAD, register-register ALU ops and HALT.

---
 rtl/cpu_core_param_if.sv | 40 ++++
 rtl/cpu_core_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_core_param_if
//  Purpose  : Groups the control, program-load, I/O and debug signals of the
//             parametrised accumulator CPU core into one bundle.
//             master = environment/loader side, slave = core side.
//  Revision : 1.0  initial release
// ============================================================================
interface cpu_core_param_if #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 3
);
    localparam int IW    = 6 + DATA_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic                    PC_Enable;
    logic                    RAM_Write_Enable;
    logic [ADDR_W-1:0]       RAM_Write_Address;
    logic [IW-1:0]           RAM_Write_Data;
    logic [DATA_W-1:0]       InD;
    logic                    InE;
    logic [DATA_W-1:0]       OutD;
    logic [ADDR_W-1:0]       PC;
    logic [IW-1:0]           PI;
    logic [1:0]              flags;
    logic                    halted;
    logic [4*DATA_W-1:0]     reg_dump;
    logic [DEPTH*IW-1:0]     ram_dump;

    modport master (
        output PC_Enable, RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data, InD, InE,
        input  OutD, PC, PI, flags, halted, reg_dump, ram_dump
    );

    modport slave (
        input  PC_Enable, RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data, InD, InE,
        output OutD, PC, PI, flags, halted, reg_dump, ram_dump
    );
endinterface
`default_nettype wire

// File: rtl/cpu_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_core_param
//  Purpose  : Multi-cycle (FETCH/EXEC) accumulator-style CPU with four
//             DATA_W-bit registers, a unified 2^ADDR_W-word program/data RAM,
//             reg-imm / reg-reg ALU ops, conditional jumps, LOAD/STORE, HALT.
//             Instruction: [IW-1:IW-2] class, [IW-3:IW-4] sub, [IW-5:IW-6] rd,
//             [DATA_W-1:0] imm (rs = top two imm bits).
//  Revision : 1.0  initial release
// ============================================================================
module cpu_core_param #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_core_param_if.slave    bus
);
    localparam int IW    = 6 + DATA_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [IW-1:0]       pi_q, pi_d;
    logic [1:0]          flags_q, flags_d;      // {C,Z}
    logic [DATA_W-1:0]   rf_q [4];
    logic [IW-1:0]       ram_q [DEPTH];

    // Execute-stage side effects produced by the decoder
    logic                rf_we_d;
    logic [DATA_W-1:0]   rf_wd_d;
    logic                st_we_d;

    // Instruction fields of the latched instruction
    logic [1:0]          w_cls, w_sub, w_rd, w_rs;
    logic [DATA_W-1:0]   w_imm, w_rd_val, w_rs_val;
    logic [ADDR_W-1:0]   w_mem_addr, w_pc_inc;

    // Datapath results
    logic [DATA_W:0]     w_add_imm, w_add_reg;
    logic [DATA_W-1:0]   w_sub_imm, w_sub_reg, w_and_reg;
    logic [2*DATA_W-1:0] w_shl_ext;
    logic                w_take;

    assign w_cls      = pi_q[IW-1:IW-2];
    assign w_sub      = pi_q[IW-3:IW-4];
    assign w_rd       = pi_q[IW-5:IW-6];
    assign w_imm      = pi_q[DATA_W-1:0];
    assign w_rs       = w_imm[DATA_W-1:DATA_W-2];
    assign w_rd_val   = rf_q[w_rd];
    assign w_rs_val   = rf_q[w_rs];
    assign w_mem_addr = w_rs_val[ADDR_W-1:0];
    assign w_pc_inc   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    assign w_add_imm  = {1'b0, w_rd_val} + {1'b0, w_imm};
    assign w_add_reg  = {1'b0, w_rd_val} + {1'b0, w_rs_val};
    assign w_sub_imm  = w_rd_val - w_imm;
    assign w_sub_reg  = w_rd_val - w_rs_val;
    assign w_and_reg  = w_rd_val & w_rs_val;
    // Shifting a double-width copy keeps the last bit shifted out at [DATA_W];
    // shift amounts >= DATA_W naturally clear the low half.
    assign w_shl_ext  = {{DATA_W{1'b0}}, w_rd_val} << w_imm;

    // Jump condition evaluated against the current flags
    always_comb begin
        w_take = 1'b0;
        case (w_sub)
            2'b00:   w_take = 1'b1;
            2'b01:   w_take = flags_q[0];
            2'b10:   w_take = ~flags_q[0];
            default: w_take = flags_q[1];
        endcase
    end

    // Next-state, decode and execute; nothing moves while PC_Enable is low
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pi_d    = pi_q;
        flags_d = flags_q;
        rf_we_d = 1'b0;
        rf_wd_d = '0;
        st_we_d = 1'b0;
        if (bus.PC_Enable) begin
            case (state_q)
                ST_FETCH: begin
                    pi_d    = ram_q[pc_q];
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    pc_d    = w_pc_inc;
                    case (w_cls)
                        2'b00: begin
                            case (w_sub)
                                2'b00: begin
                                    rf_we_d = 1'b1;
                                    rf_wd_d = w_add_imm[DATA_W-1:0];
                                    flags_d = {w_add_imm[DATA_W], w_add_imm[DATA_W-1:0] == '0};
                                end
                                2'b01: begin
                                    flags_d = {w_rd_val < w_imm, w_sub_imm == '0};
                                end
                                2'b10: begin
                                    rf_we_d = 1'b1;
                                    rf_wd_d = w_shl_ext[DATA_W-1:0];
                                    flags_d = {w_shl_ext[DATA_W], w_shl_ext[DATA_W-1:0] == '0};
                                end
                                default: begin
                                    rf_we_d = 1'b1;
                                    rf_wd_d = w_sub_imm;
                                    flags_d = {w_rd_val < w_imm, w_sub_imm == '0};
                                end
                            endcase
                        end
                        2'b01: begin
                            if (w_take) begin
                                pc_d = w_imm[ADDR_W-1:0];
                            end
                        end
                        2'b10: begin
                            case (w_sub)
                                2'b00: st_we_d = 1'b1;
                                2'b01: begin
                                    rf_we_d = 1'b1;
                                    rf_wd_d = ram_q[w_mem_addr][DATA_W-1:0];
                                end
                                2'b10: begin
                                    // PC stays on the HALT instruction
                                    state_d = ST_HALT;
                                    pc_d    = pc_q;
                                end
                                default: ;
                            endcase
                        end
                        default: begin
                            rf_we_d = 1'b1;
                            case (w_sub)
                                2'b00: begin
                                    rf_wd_d = w_add_reg[DATA_W-1:0];
                                    flags_d = {w_add_reg[DATA_W], w_add_reg[DATA_W-1:0] == '0};
                                end
                                2'b01: begin
                                    rf_wd_d = w_sub_reg;
                                    flags_d = {w_rd_val < w_rs_val, w_sub_reg == '0};
                                end
                                2'b10: begin
                                    rf_wd_d = w_and_reg;
                                    flags_d = {1'b0, w_and_reg == '0};
                                end
                                default: rf_wd_d = w_rs_val;
                            endcase
                        end
                    endcase
                end
                ST_HALT: ;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // Control state: FSM, program counter, instruction latch, flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            pi_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pi_q    <= pi_d;
            flags_q <= flags_d;
        end
    end

    // Register file; an EXEC write to R2 overrides the InD load in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (bus.InE) begin
                rf_q[2] <= bus.InD;
            end
            if (rf_we_d) begin
                rf_q[w_rd] <= rf_wd_d;
            end
        end
    end

    // Unified RAM; the external write port wins and a colliding STORE is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ram_q[k] <= '0;
            end
        end else if (bus.RAM_Write_Enable) begin
            ram_q[bus.RAM_Write_Address] <= bus.RAM_Write_Data;
        end else if (st_we_d) begin
            ram_q[w_mem_addr] <= {{(IW-DATA_W){1'b0}}, w_rd_val};
        end
    end

    assign bus.OutD     = rf_q[3];
    assign bus.PC       = pc_q;
    assign bus.PI       = pi_q;
    assign bus.flags    = flags_q;
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.reg_dump = {rf_q[3], rf_q[2], rf_q[1], rf_q[0]};

    // Flatten the RAM for observation
    always_comb begin
        bus.ram_dump = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.ram_dump[k*IW +: IW] = ram_q[k];
        end
    end
endmodule
`default_nettype wire
